// File: rtl/auth_msg_tx.sv
// Serialises one captured authentication message onto a byte stream and then
// supervises the responder reply window. Optional counters: AUTH_MSG_TX_STATS_EN.
module auth_msg_tx #(
    parameter int unsigned HDR_BYTES = 4,
    parameter int unsigned PAY_BYTES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   msg_valid,
    input  logic [HDR_BYTES*8-1:0] header,
    input  logic [PAY_BYTES*8-1:0] payload,
    input  logic [15:0]            wLength,
    input  logic [31:0]            timeout,
    output logic                   msg_ack,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   tx_last,
    input  logic                   rsp_start,
    output logic                   rsp_ok,
    output logic                   timeout_err,
    output logic                   busy
`ifdef AUTH_MSG_TX_STATS_EN
    ,
    output logic [15:0]            msgs_sent,
    output logic [7:0]             timeouts
`endif
);

    localparam int unsigned MsgBytes = HDR_BYTES + PAY_BYTES;
    localparam int unsigned MsgW     = MsgBytes * 8;
    localparam int unsigned IdxW     = $clog2(MsgBytes + 1);

    typedef enum logic [1:0] {StIdle, StSend, StWaitRsp} state_e;

    state_e            state_q, state_d;
    logic [MsgW-1:0]   msg_q, msg_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [IdxW-1:0]   len_q, len_d;
    logic [31:0]       tmo_q, tmo_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              tx_valid_q, tx_valid_d;
    logic              tx_last_q, tx_last_d;
    logic              msg_ack_q, msg_ack_d;
    logic              rsp_ok_q, rsp_ok_d;
    logic              timeout_err_q, timeout_err_d;
    logic              busy_q, busy_d;
    logic [15:0]       pay_len;
    logic [IdxW-1:0]   cap_len;

    assign pay_len = (wLength > 16'(PAY_BYTES)) ? 16'(PAY_BYTES) : wLength;
    assign cap_len = IdxW'(HDR_BYTES) + IdxW'(pay_len);

    always_comb begin
        state_d       = state_q;
        msg_d         = msg_q;
        idx_d         = idx_q;
        len_d         = len_q;
        tmo_d         = tmo_q;
        cnt_d         = cnt_q;
        tx_valid_d    = tx_valid_q;
        tx_last_d     = tx_last_q;
        busy_d        = busy_q;
        msg_ack_d     = 1'b0;
        rsp_ok_d      = 1'b0;
        timeout_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (msg_valid) begin
                    msg_d      = {payload, header};
                    tmo_d      = timeout;
                    len_d      = cap_len;
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
                    tx_last_d  = (cap_len == IdxW'(1));
                    busy_d     = 1'b1;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (tx_valid_q) begin
                    if (tx_ready) begin
                        // The current byte always sits in msg_q[7:0].
                        msg_d = msg_q >> 8;
                        idx_d = idx_q + IdxW'(1);
                        if (tx_last_q) begin
                            tx_valid_d = 1'b0;
                            tx_last_d  = 1'b0;
                            msg_ack_d  = 1'b1;
                        end else begin
                            tx_last_d = ((idx_q + IdxW'(1)) == (len_q - IdxW'(1)));
                        end
                    end
                end else begin
                    // msg_ack cycle: leave SEND afterwards.
                    if (tmo_q == 32'd0) begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        cnt_d   = '0;
                        state_d = StWaitRsp;
                    end
                end
            end
            StWaitRsp: begin
                cnt_d = cnt_q + 32'd1;
                if (rsp_start) begin
                    rsp_ok_d = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = StIdle;
                end else if (cnt_q == tmo_q - 32'd1) begin
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = StIdle;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            msg_q         <= '0;
            idx_q         <= '0;
            len_q         <= '0;
            tmo_q         <= '0;
            cnt_q         <= '0;
            tx_valid_q    <= 1'b0;
            tx_last_q     <= 1'b0;
            msg_ack_q     <= 1'b0;
            rsp_ok_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            msg_q         <= msg_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            tmo_q         <= tmo_d;
            cnt_q         <= cnt_d;
            tx_valid_q    <= tx_valid_d;
            tx_last_q     <= tx_last_d;
            msg_ack_q     <= msg_ack_d;
            rsp_ok_q      <= rsp_ok_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
        end
    end

    assign msg_ack     = msg_ack_q;
    assign tx_data     = msg_q[7:0];
    assign tx_valid    = tx_valid_q;
    assign tx_last     = tx_last_q;
    assign rsp_ok      = rsp_ok_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

`ifdef AUTH_MSG_TX_STATS_EN
    logic [15:0] msgs_sent_q, msgs_sent_d;
    logic [7:0]  timeouts_q, timeouts_d;

    always_comb begin
        msgs_sent_d = msgs_sent_q + (msg_ack_d ? 16'd1 : 16'd0);
        timeouts_d  = timeouts_q;
        if (timeout_err_d && (timeouts_q != 8'hFF)) begin
            timeouts_d = timeouts_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            msgs_sent_q <= '0;
            timeouts_q  <= '0;
        end else begin
            msgs_sent_q <= msgs_sent_d;
            timeouts_q  <= timeouts_d;
        end
    end

    assign msgs_sent = msgs_sent_q;
    assign timeouts  = timeouts_q;
`endif

endmodule

// File: tb/tb_auth_msg_tx.sv
// Randomised directed bench for auth_msg_tx; expected bytes and pulses come from a
// message-level model. Define AUTH_MSG_TX_STATS_EN to also check the counters.
module tb_auth_msg_tx;

    logic        clk = 1'b0;
    logic        reset, msg_valid, tx_ready, rsp_start;
    logic [31:0] header;
    logic [63:0] payload;
    logic [15:0] wLength;
    logic [31:0] timeout;
    logic        msg_ack, tx_valid, tx_last, rsp_ok, timeout_err, busy;
    logic [7:0]  tx_data;
`ifdef AUTH_MSG_TX_STATS_EN
    logic [15:0] msgs_sent;
    logic [7:0]  timeouts;
`endif

    int checks = 0;
    int errors = 0;
    int exp_msgs = 0;
    int exp_tmos = 0;

    always #5 clk = ~clk;

    auth_msg_tx #(.HDR_BYTES(4), .PAY_BYTES(8)) dut (
        .clk(clk), .reset(reset), .msg_valid(msg_valid), .header(header),
        .payload(payload), .wLength(wLength), .timeout(timeout), .msg_ack(msg_ack),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
        .rsp_start(rsp_start), .rsp_ok(rsp_ok), .timeout_err(timeout_err), .busy(busy)
`ifdef AUTH_MSG_TX_STATS_EN
        , .msgs_sent(msgs_sent), .timeouts(timeouts)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag);
`ifdef AUTH_MSG_TX_STATS_EN
        chk({tag, "_msgs_sent"}, 32'(msgs_sent), 32'(exp_msgs & 16'hFFFF));
        chk({tag, "_timeouts"}, 32'(timeouts), 32'(exp_tmos));
`endif
    endtask

    // One complete transaction; returns at a negedge of an IDLE cycle.
    task automatic run_msg(input logic [31:0] hdr, input logic [63:0] pay,
                           input logic [15:0] wlen, input logic [31:0] tmo,
                           input int rmode, input int rsp_at, input bit hold);
        logic [95:0] msg, sh;
        int          len, k, cyc;
        logic        rdy;
        msg = {pay, hdr};
        len = 4 + ((wlen > 16'd8) ? 8 : int'(wlen));
        header = hdr; payload = pay; wLength = wlen; timeout = tmo;
        msg_valid = 1'b1;
        rsp_start = 1'b0;
        @(negedge clk);
        if (!hold) msg_valid = 1'b0;
        k = 0;
        cyc = 1;
        while (k < len && cyc < 300) begin
            sh = msg >> (8 * k);
            chk("tx_valid", 32'(tx_valid), 32'd1);
            chk("tx_data", 32'(tx_data), 32'(sh[7:0]));
            chk("tx_last", 32'(tx_last), 32'(k == len - 1));
            chk("busy_send", 32'(busy), 32'd1);
            chk("ack_early", 32'(msg_ack), 32'd0);
            chk("pulses_send", 32'({rsp_ok, timeout_err}), 32'd0);
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 1);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tx_ready  = rdy;
            rsp_start = 1'($urandom_range(0, 1));
            if (rdy) k++;
            @(negedge clk);
            cyc++;
        end
        if (k < len) chk("send_bound", 32'(k), 32'(len));
        tx_ready  = 1'($urandom_range(0, 1));
        rsp_start = 1'($urandom_range(0, 1));
        exp_msgs++;
        chk("msg_ack", 32'(msg_ack), 32'd1);
        chk("tx_valid_ack", 32'(tx_valid), 32'd0);
        chk("busy_ack", 32'(busy), 32'd1);
        if (rmode == 0) chk("ack_latency", 32'(cyc), 32'(len + 1));
        chk_stats("ack");
        if (tmo == 32'd0) begin
            @(negedge clk);
            rsp_start = 1'b0;
            chk("busy_idle", 32'(busy), 32'd0);
            chk("quiet_idle", 32'({msg_ack, tx_valid, rsp_ok, timeout_err}), 32'd0);
        end else begin
            for (int c = 0; c < int'(tmo); c++) begin
                @(negedge clk);
                chk("busy_wait", 32'(busy), 32'd1);
                chk("quiet_wait", 32'({msg_ack, tx_valid, rsp_ok, timeout_err}), 32'd0);
                rsp_start = (c == rsp_at);
                if (c == rsp_at) break;
            end
            @(negedge clk);
            rsp_start = 1'b0;
            chk("busy_end", 32'(busy), 32'd0);
            if (rsp_at >= 0 && rsp_at < int'(tmo)) begin
                chk("rsp_ok", 32'(rsp_ok), 32'd1);
                chk("no_tmo_err", 32'(timeout_err), 32'd0);
            end else begin
                if (exp_tmos < 255) exp_tmos++;
                chk("no_rsp_ok", 32'(rsp_ok), 32'd0);
                chk("timeout_err", 32'(timeout_err), 32'd1);
            end
            chk_stats("rsp");
        end
    endtask

    initial begin
        int wl, tm, ra, rm;
        reset = 1'b1; msg_valid = 1'b0; tx_ready = 1'b0; rsp_start = 1'b0;
        header = '0; payload = '0; wLength = '0; timeout = '0;
        repeat (2) @(negedge clk);
        chk("rst_outs", 32'({msg_ack, tx_valid, tx_last, rsp_ok, timeout_err, busy}), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk_stats("rst");
        reset = 1'b0;
        @(negedge clk);

        run_msg(32'hA1B2C3D4, {$urandom, $urandom}, 16'd0, 32'd0, 0, -1, 1'b0);
        run_msg($urandom, {$urandom, 8'($urandom), 24'h112233}, 16'd3, 32'd0, 1, -1, 1'b0);
        run_msg($urandom, {$urandom, $urandom}, 16'd5, 32'd10, 2, 4, 1'b0);
        run_msg($urandom, {$urandom, $urandom}, 16'd8, 32'd10, 0, -1, 1'b0);
        run_msg($urandom, {$urandom, $urandom}, 16'd2, 32'd10, 0, 9, 1'b0);
        run_msg(32'h0BADF00D, 64'h0123456789ABCDEF, 16'd20, 32'd0, 0, -1, 1'b1);
        run_msg(32'h0BADF00D, 64'h0123456789ABCDEF, 16'd20, 32'd0, 0, -1, 1'b0);

        for (int n = 0; n < 20; n++) begin
            wl = $urandom_range(0, 12);
            tm = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15);
            ra = (tm == 0) ? -1 : $urandom_range(0, tm);
            if (ra == tm) ra = -1;
            rm = $urandom_range(0, 2);
            run_msg($urandom, {$urandom, $urandom}, 16'(wl), 32'(tm), rm, ra, 1'b0);
        end

        // Abort in the middle of SEND while byte 2 is presented.
        header = 32'h44332211; payload = 64'h8877665544332211; wLength = 16'd8;
        timeout = 32'd5; msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_byte2", 32'(tx_data), 32'h33);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_msgs = 0;
        exp_tmos = 0;
        chk("abort_outs", 32'({msg_ack, tx_valid, tx_last, rsp_ok, timeout_err, busy}), 32'd0);
        chk("abort_data", 32'(tx_data), 32'd0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("abort_quiet", 32'({msg_ack, tx_valid, rsp_ok, timeout_err, busy}), 32'd0);
        end
        chk_stats("abort");

        run_msg($urandom, {$urandom, $urandom}, 16'd4, 32'd0, 0, -1, 1'b0);
        run_msg($urandom, {$urandom, $urandom}, 16'd1, 32'd6, 2, -1, 1'b0);
        chk_stats("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
